// File: rtl/lcd_host.sv
// Host sequencer for the 12x9 LCD controller: issues commands, streams the 108-byte image and collects 16 result pixels per command.
// Latency: one issue cycle after acceptance; the image byte reaches the controller one cycle after its read; each pixel is returned one cycle after capture.
// Backpressure: req_ready is high only in IDLE while the controller is not busy; the result port has no backpressure.
module lcd_host #(
    parameter int IMG_BYTES = 108,
    parameter int OUT_PIX   = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [2:0] req_cmd,
    output logic       req_ready,
    output logic       img_rd,
    output logic [6:0] img_addr,
    input  logic [7:0] img_data,
    output logic [2:0] lcd_cmd,
    output logic       lcd_cmd_valid,
    output logic [7:0] lcd_datain,
    input  logic [7:0] lcd_dataout,
    input  logic       lcd_output_valid,
    input  logic       lcd_busy,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic [3:0] res_idx,
    output logic       cmd_done,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, ISSUE, LOAD, COLLECT} state_t;

    localparam logic [2:0] CMD_LOAD    = 3'd0;
    localparam logic [2:0] CMD_ILLEGAL = 3'd7;
    localparam logic [6:0] LAST_ADDR   = 7'(IMG_BYTES - 1);
    localparam logic [3:0] LAST_PIX    = 4'(OUT_PIX - 1);
    localparam logic [7:0] WDOG_LAST   = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [2:0] cmd_q, cmd_d;
    logic [6:0] addr_q, addr_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] wdog_q, wdog_d;
    logic       res_valid_q, res_valid_d;
    logic [7:0] res_data_q, res_data_d;
    logic [3:0] res_idx_q, res_idx_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    // Image bytes pass straight through so the memory's one-cycle read latency sets the alignment.
    assign lcd_datain = img_data;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_idx    = res_idx_q;
    assign cmd_done   = done_q;
    assign err        = err_q;

    // State and result registers; reset drops everything, no completion is reported for an aborted command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_q       <= 3'd0;
            addr_q      <= 7'd0;
            cnt_q       <= 4'd0;
            wdog_q      <= 8'd0;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'd0;
            res_idx_q   <= 4'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            wdog_q      <= wdog_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_idx_q   <= res_idx_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next-state and controller-facing strobes for the IDLE/ISSUE/LOAD/COLLECT sequence.
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        wdog_d        = wdog_q;
        res_valid_d   = 1'b0;
        res_data_d    = res_data_q;
        res_idx_d     = res_idx_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        req_ready     = 1'b0;
        lcd_cmd_valid = 1'b0;
        lcd_cmd       = 3'd0;
        img_rd        = 1'b0;
        img_addr      = 7'd0;
        case (state_q)
            IDLE: begin
                // Gated by reset so the port reads 0 while reset is held.
                req_ready = !lcd_busy && !reset;
                if (req_valid && !lcd_busy) begin
                    cmd_d = req_cmd;
                    if (req_cmd == CMD_ILLEGAL) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                lcd_cmd_valid = 1'b1;
                lcd_cmd       = cmd_q;
                cnt_d         = 4'd0;
                wdog_d        = 8'd0;
                if (cmd_q == CMD_LOAD) begin
                    // Address 0 is read alongside the command so byte k lands k+1 cycles later.
                    img_rd   = 1'b1;
                    img_addr = 7'd0;
                    addr_d   = 7'd1;
                    state_d  = LOAD;
                end else begin
                    state_d = COLLECT;
                end
            end
            LOAD: begin
                img_rd   = 1'b1;
                img_addr = addr_q;
                if (addr_q == LAST_ADDR) begin
                    addr_d  = 7'd0;
                    state_d = COLLECT;
                end else begin
                    addr_d = addr_q + 7'd1;
                end
            end
            COLLECT: begin
                if (lcd_output_valid) begin
                    res_valid_d = 1'b1;
                    res_data_d  = lcd_dataout;
                    res_idx_d   = cnt_q;
                    wdog_d      = 8'd0;
                    if (cnt_q == LAST_PIX) begin
                        done_d  = 1'b1;
                        cnt_d   = 4'd0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else if (wdog_q == WDOG_LAST) begin
                    // The idle count has hit TIMEOUT: abandon the command.
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    cnt_d   = 4'd0;
                    wdog_d  = 8'd0;
                    state_d = IDLE;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lcd_host.sv
// Bench for lcd_host: image memory and LCD controller models, command vector table with pixel scoreboard.
// Latency: checks 1-cycle image alignment, 1-cycle capture, and the timeout abort distance.
// Backpressure: commands wait on req_ready; the controller model inserts random output gaps and can stall.
module tb_lcd_host;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [2:0] req_cmd;
    logic       req_ready;
    logic       img_rd;
    logic [6:0] img_addr;
    logic [7:0] img_data;
    logic [2:0] lcd_cmd;
    logic       lcd_cmd_valid;
    logic [7:0] lcd_datain;
    logic [7:0] lcd_dataout;
    logic       lcd_output_valid;
    logic       lcd_busy;
    logic       res_valid;
    logic [7:0] res_data;
    logic [3:0] res_idx;
    logic       cmd_done;
    logic       err;

    lcd_host dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_cmd(req_cmd), .req_ready(req_ready),
        .img_rd(img_rd), .img_addr(img_addr), .img_data(img_data),
        .lcd_cmd(lcd_cmd), .lcd_cmd_valid(lcd_cmd_valid), .lcd_datain(lcd_datain),
        .lcd_dataout(lcd_dataout), .lcd_output_valid(lcd_output_valid), .lcd_busy(lcd_busy),
        .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx),
        .cmd_done(cmd_done), .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cur_vec = -1;
    int cyc = 0;
    int last_res_cyc = 0;
    int cv_count = 0;
    logic [2:0] cur_cmd = 3'd0;
    bit stall_mode = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (vec %0d): got 0x%0h, expected 0x%0h", nm, cur_vec, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- image memory: img_mem[i] = i, one-cycle read ----------------
    logic [7:0] img_mem [108];
    initial for (int i = 0; i < 108; i++) img_mem[i] = 8'(i);

    always @(posedge clk or posedge reset) begin
        if (reset) img_data <= 8'd0;
        else if (img_rd) img_data <= (img_addr < 7'd108) ? img_mem[img_addr] : 8'hEE;
    end

    // ---------------- LCD controller model ----------------
    typedef enum {C_IDLE, C_LOAD, C_OUT, C_HOLD, C_STALL} cst_t;
    cst_t cst;
    int ld_n, out_n, ox, oy;
    bit fit;
    logic [7:0] cmem [108];

    function automatic logic [7:0] ctl_pix(input int n);
        int r, c;
        r = n / 4;
        c = n % 4;
        if (fit) return cmem[(1 + 2 * r) * 12 + 1 + 3 * c];
        return cmem[(oy + r) * 12 + ox + c];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cst <= C_IDLE; lcd_busy <= 1'b0; lcd_output_valid <= 1'b0; lcd_dataout <= 8'd0;
            fit <= 1'b1; ox <= 4; oy <= 3; ld_n <= 0; out_n <= 0;
        end else if (lcd_cmd_valid) begin
            lcd_output_valid <= 1'b0;
            lcd_busy <= 1'b1;
            out_n <= 0;
            cst <= C_OUT;
            case (lcd_cmd)
                3'd0: begin cst <= C_LOAD; ld_n <= 0; end
                3'd1: fit <= 1'b0;
                3'd2: fit <= 1'b1;
                3'd3: if (!fit && ox < 8) ox <= ox + 1;
                3'd4: if (!fit && ox > 0) ox <= ox - 1;
                3'd5: if (!fit && oy > 0) oy <= oy - 1;
                3'd6: if (!fit && oy < 5) oy <= oy + 1;
                default: ;
            endcase
        end else begin
            case (cst)
                C_LOAD: begin
                    cmem[ld_n] <= lcd_datain;
                    ld_n <= ld_n + 1;
                    if (ld_n == 107) begin
                        cst <= C_OUT; fit <= 1'b1; ox <= 4; oy <= 3;
                    end
                end
                C_OUT: begin
                    if (stall_mode && out_n == 5) begin
                        cst <= C_STALL; lcd_output_valid <= 1'b0; lcd_busy <= 1'b0;
                    end else if ($urandom_range(0, 3) == 0) begin
                        lcd_output_valid <= 1'b0;
                    end else begin
                        lcd_output_valid <= 1'b1;
                        lcd_dataout <= ctl_pix(out_n);
                        out_n <= out_n + 1;
                        if (out_n == 15) begin cst <= C_HOLD; lcd_busy <= 1'b0; end
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- scoreboard and protocol monitor ----------------
    typedef struct packed { logic [3:0] idx; logic [7:0] dat; } exp_t;
    exp_t sb[$];
    bit   dk_act = 1'b0;
    int   dk = 0;
    int   rd_run = 0;
    logic prev_cv = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            dk_act = 1'b0; rd_run = 0; prev_cv = 1'b0;
        end else begin
            if (res_valid) begin
                last_res_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("res_unexpected", {4'(res_idx), res_data}, 12'hFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("res_idx", res_idx, e.idx);
                    chk("res_data", res_data, e.dat);
                end
            end
            if (dk_act) begin
                chk("lcd_datain", lcd_datain, 8'(dk));
                dk++;
                if (dk == 108) dk_act = 1'b0;
            end
            if (img_rd) rd_run++;
            else if (rd_run != 0) begin
                chk("img_rd_len", rd_run, 108);
                rd_run = 0;
            end
            if (err && !cmd_done) chk("err_without_done", cmd_done, 1);
            if (lcd_cmd_valid) begin
                cv_count++;
                chk("cmd_valid_one_cycle", prev_cv, 0);
                chk("ready_low_in_issue", req_ready, 0);
                chk("lcd_cmd", lcd_cmd, cur_cmd);
                if (lcd_cmd == 3'd0) begin dk_act = 1'b1; dk = 0; end
            end
            prev_cv = lcd_cmd_valid;
        end
    end

    // ---------------- command vector table ----------------
    typedef struct packed {
        logic [2:0]       cmd;
        logic             err;
        logic             stall;
        logic [15:0][7:0] pix;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    function automatic logic [15:0][7:0] zoom_pix(input int x, input int y);
        logic [15:0][7:0] p;
        for (int i = 0; i < 16; i++) p[i] = 8'(12 * (y + i / 4) + x + i % 4);
        return p;
    endfunction

    function automatic logic [15:0][7:0] fit_pix();
        logic [15:0][7:0] p;
        byte unsigned t [16];
        t = '{13, 16, 19, 22, 37, 40, 43, 46, 61, 64, 67, 70, 85, 88, 91, 94};
        for (int i = 0; i < 16; i++) p[i] = t[i];
        return p;
    endfunction

    task automatic set_vec(input int i, input logic [2:0] c, input logic e, input logic s,
                           input logic [15:0][7:0] p);
        vecs[i].cmd = c; vecs[i].err = e; vecs[i].stall = s; vecs[i].pix = p;
    endtask

    task automatic run_cmd(input vec_t v);
        int w, n, cv0;
        n = v.stall ? 5 : (v.err ? 0 : 16);
        for (int i = 0; i < n; i++) sb.push_back({4'(i), v.pix[i]});
        stall_mode = v.stall;
        cur_cmd = v.cmd;
        cv0 = cv_count;
        w = 0;
        while (!req_ready && w < 2000) begin @(negedge clk); w++; end
        chk("req_ready_wait", req_ready, 1);
        req_valid = 1'b1;
        req_cmd = v.cmd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        w = 0;
        do begin @(negedge clk); w++; end while (!cmd_done && w < 3000);
        #1;
        chk("cmd_done_seen", cmd_done, 1);
        chk("err_flag", err, v.err);
        if (v.cmd == 3'd7) chk("illegal_done_latency", w, 1);
        if (v.stall) begin
            chk("timeout_distance", cyc - last_res_cyc, 255);
            chk("ready_after_abort", req_ready, 1);
        end
        chk("cmd_valid_count", cv_count - cv0, (v.cmd == 3'd7) ? 0 : 1);
        chk("pixels_outstanding", sb.size(), 0);
        sb.delete();
        stall_mode = 1'b0;
    endtask

    function automatic logic [63:0] all_outs();
        return {req_ready, img_rd, img_addr, lcd_cmd, lcd_cmd_valid, lcd_datain,
                res_valid, res_data, res_idx, cmd_done, err};
    endfunction

    initial begin
        int w;
        reset = 1'b0; req_valid = 1'b0; req_cmd = 3'd0;
        set_vec(0,  3'd0, 1'b0, 1'b0, fit_pix());        // LOAD_DATA
        set_vec(1,  3'd1, 1'b0, 1'b0, zoom_pix(4, 3));   // ZOOM_IN
        set_vec(2,  3'd3, 1'b0, 1'b0, zoom_pix(5, 3));   // SHIFT_RIGHT
        set_vec(3,  3'd6, 1'b0, 1'b0, zoom_pix(5, 4));   // SHIFT_DOWN
        set_vec(4,  3'd4, 1'b0, 1'b0, zoom_pix(4, 4));   // SHIFT_LEFT
        set_vec(5,  3'd5, 1'b0, 1'b0, zoom_pix(4, 3));   // SHIFT_UP
        set_vec(6,  3'd2, 1'b0, 1'b0, fit_pix());        // ZOOM_FIT
        set_vec(7,  3'd4, 1'b0, 1'b0, fit_pix());        // SHIFT_LEFT in fit mode
        set_vec(8,  3'd7, 1'b1, 1'b0, '0);               // illegal code
        set_vec(9,  3'd1, 1'b0, 1'b0, zoom_pix(4, 3));   // ZOOM_IN right after illegal
        set_vec(10, 3'd1, 1'b1, 1'b1, zoom_pix(4, 3));   // controller stalls after 5 pixels
        set_vec(11, 3'd3, 1'b0, 1'b0, zoom_pix(5, 3));   // recovery after timeout

        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", req_ready, 1);

        for (int i = 0; i < NV; i++) begin
            cur_vec = i;
            run_cmd(vecs[i]);
        end

        // Reset in the middle of an image load.
        cur_vec = 100;
        cur_cmd = 3'd0;
        w = 0;
        while (!req_ready && w < 2000) begin @(negedge clk); w++; end
        req_valid = 1'b1; req_cmd = 3'd0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        w = 0;
        while (!(img_rd && img_addr == 7'd50) && w < 500) begin @(negedge clk); w++; end
        chk("reached_addr_50", img_addr, 50);
        #1 reset = 1'b1;
        #1 chk("mid_load_reset_outputs", all_outs(), 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_mid_reset", req_ready, 1);
        chk("no_done_after_abort", cmd_done, 0);

        cur_vec = 0;
        run_cmd(vecs[0]);
        cur_vec = 1;
        run_cmd(vecs[1]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

endmodule
